// File: rtl/hf_array_feeder_if.sv
// Array-feeder bus: producer write handshake plus the skewed lane outputs
// toward the systolic array edge, advanced by out_en.
interface hf_array_feeder_if #(
  parameter int LANES = 4,
  parameter int EW    = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [LANES*EW-1:0]   in_data;
  logic                  out_en;
  logic [LANES*EW-1:0]   out_data;
  logic [LANES-1:0]      out_valid;

  modport master (
    output in_valid, in_data, out_en,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_valid, in_data, out_en,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/hf_array_feeder.sv
// Circular word FIFO feeding a systolic array edge through a triangular skew
// pipe; batch mode fills (or flushes) then drains, stream mode drains on demand.
module hf_array_feeder #(
  parameter int LANES = 4,
  parameter int EW    = 8,
  parameter int D     = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 mode,
  input  logic                 flush,
  hf_array_feeder_if.slave     bus,
  output logic [$clog2(D):0]   count,
  output logic                 full,
  output logic                 empty,
  output logic                 busy,
  output logic                 done
);

  localparam int AW = $clog2(D);
  localparam int PW = AW + 1;
  localparam int TW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [TW-1:0] TAIL_LAST = TW'((LANES > 1) ? LANES - 2 : 0);

  typedef enum logic [1:0] {IDLE, DRAIN, TAIL} state_t;

  state_t              state, state_nxt;
  logic                mode_q, mode_nxt;
  logic [TW-1:0]       tail_cnt, tail_nxt;
  logic                done_nxt;
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [LANES*EW-1:0] mem [D];
  logic [LANES*EW-1:0] rd_word;
  logic                mode_eff, in_rdy, wr_en, pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;
  assign busy  = (state != IDLE);

  // Mode is live while idle and frozen for the duration of a drain/tail pass.
  assign mode_eff = (state == IDLE) ? mode : mode_q;
  assign in_rdy   = ~full & (mode_eff | (state == IDLE));
  assign bus.in_ready = in_rdy;

  assign wr_en   = bus.in_valid & in_rdy;
  assign pop     = (state == DRAIN) & bus.out_en & ~empty;
  assign rd_word = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= bus.in_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      state    <= IDLE;
      mode_q   <= 1'b0;
      tail_cnt <= '0;
      done     <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      state    <= state_nxt;
      mode_q   <= mode_nxt;
      tail_cnt <= tail_nxt;
      done     <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mode_nxt  = mode_q;
    tail_nxt  = tail_cnt;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (mode ? ~empty : (full | (flush & ~empty))) begin
          state_nxt = DRAIN;
          mode_nxt  = mode;
        end
      end
      DRAIN: begin
        if (pop && (count == PW'(1)) && !wr_en) begin
          state_nxt = TAIL;
          tail_nxt  = '0;
        end
      end
      TAIL: begin
        // Stream refill during the tail resumes draining without a done pulse.
        if (mode_q && !empty) begin
          state_nxt = DRAIN;
          tail_nxt  = '0;
        end else if (bus.out_en) begin
          if (tail_cnt == TAIL_LAST) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            tail_nxt = tail_cnt + TW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Skew pipe: stage p0 captures the popped lane, lane i adds i more stages.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam int VW = i + 1;
    localparam int CW = (i + 1) * EW;
    logic [VW-1:0] vld_p;
    logic [CW-1:0] dat_p;
    logic [EW-1:0] lane_in;

    assign lane_in = pop ? rd_word[i*EW +: EW] : '0;

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        vld_p <= '0;
        dat_p <= '0;
      end else if (bus.out_en) begin
        vld_p <= (vld_p << 1) | VW'(pop);
        dat_p <= (dat_p << EW) | CW'(lane_in);
      end
    end

    assign bus.out_valid[i]          = vld_p[i];
    assign bus.out_data[i*EW +: EW]  = vld_p[i] ? dat_p[i*EW +: EW] : '0;
  end

endmodule
